sap_controller: RTL and testbench
=================================

SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- step  input  1  advance enable; the T-state advances only on a clk edge with step=1.
- opcode  input  4  upper nibble of the instruction register output.
- tstate  output  6  one-hot T-state (bit0=T1 .. bit5=T6); 6'b0 when halted.
- pc_out  output  1  program counter drives bus.
- pc_inc  output  1  program counter increment.
- mar_load  output  1  memory address register loads from bus.
- mem_out  output  1  memory drives bus.
- ir_load  output  1  instruction register loads from bus.
- ir_out  output  1  instruction register low nibble drives bus.
- a_load  output  1  accumulator loads from bus.
- a_out  output  1  accumulator drives bus.
- b_load  output  1  B register loads from bus.
- alu_out  output  1  ALU drives bus.
- alu_sub  output  1  ALU subtracts (0 = add).
- out_load  output  1  output register loads from bus.
- halted  output  1  controller is in HALT.

Function
REQ-002 The block SHALL implement a Moore state machine with states T1, T2, T3, T4, T5, T6 and HALT; every output SHALL be a decode of the state and the opcode only.
REQ-003 Opcodes SHALL be: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF; every other value SHALL execute as NOP.
REQ-004 Fetch SHALL be opcode-independent: T1 asserts pc_out and mar_load; T2 asserts pc_inc; T3 asserts mem_out and ir_load.
REQ-005 T4 SHALL assert: ir_out and mar_load for LDA/ADD/SUB; a_out and out_load for OUT; nothing for HLT or NOP.
REQ-006 T5 SHALL assert: mem_out and a_load for LDA; mem_out and b_load for ADD/SUB; nothing otherwise.
REQ-007 T6 SHALL assert: alu_out and a_load for ADD; alu_out, alu_sub and a_load for SUB; nothing otherwise.
REQ-008 At most one bus-driving output (pc_out, mem_out, ir_out, a_out, alu_out) SHALL be high in any cycle.
REQ-009 With step=0, the state SHALL hold and the outputs SHALL remain stable.
REQ-010 Sequencing SHALL be T1→T2→…→T6→T1, advancing one state per stepped edge.
REQ-011 In T4 with opcode=HLT, the next stepped edge SHALL enter HALT instead of T5.
REQ-012 HALT SHALL be exited only by rst; in HALT, all control outputs and tstate SHALL be 0, halted SHALL be 1, and step SHALL be ignored.
REQ-013 The opcode SHALL be consumed only in T4–T6; opcode changes in T1–T3 SHALL have no effect.

Reset
REQ-014 Assertion of rst SHALL immediately force state T1, regardless of clk, step or current state (including mid-instruction and HALT).
REQ-015 While rst is high and after its release, outputs SHALL be: tstate=6'b000001, pc_out=1, mar_load=1, halted=0, and all other outputs 0.
REQ-016 The first stepped edge after rst deasserts SHALL advance to T2.

Configuration
REQ-017 Macro SAP_VAR_CYCLE_EN SHALL select the machine-cycle length.
REQ-018 With SAP_VAR_CYCLE_EN undefined, every non-HLT instruction SHALL take exactly 6 stepped cycles.
REQ-019 With SAP_VAR_CYCLE_EN defined, the controller SHALL return to T1 after the last active T-state:
- OUT and NOP: T4→T1 (4 cycles).
- LDA: T5→T1 (5 cycles).
- ADD and SUB: 6 cycles.
- HLT behaviour is unchanged.

Verification
REQ-020 Reset then step=1 for 6 cycles with opcode=4'h0 -> tstate walks 01,02,04,08,10,20; mar_load is high in T1 and T4; a_load is high only in T5; tstate returns to 01.
REQ-021 opcode=4'h2 through T4–T6 -> alu_sub=1 only in T6 and coincident with alu_out=1 and a_load=1; b_load=1 only in T5.
REQ-022 opcode=4'hF at T4, then 10 further stepped edges -> halted=1 from the first edge after T4; tstate and all controls are 0; rst pulse -> tstate=01 and pc_out=1.
REQ-023 step toggled 1,0,0,1 starting from T2 -> state is T3 after the first edge, holds T3 for 2 edges, then moves to T4.
REQ-024 rst asserted asynchronously mid-T5 (between clk edges) -> tstate=01 within the same cycle, before the next clk edge.
REQ-025 With SAP_VAR_CYCLE_EN defined, opcode sequence OUT, NOP(4'h5), LDA, ADD -> T1 recurs after 4, 4, 5 and 6 stepped edges respectively; with the macro undefined -> T1 recurs every 6 stepped edges.

Source files
------------

// File: rtl/sap_controller.sv
// sap_controller -- Moore control sequencer for a SAP-1 style CPU.
//
// Walks the one-hot T-states T1..T6 while step is high, decoding the
// bus control word from the current T-state and the instruction opcode.
// HLT parks the machine in HALT until rst is asserted.
//
// Build option:
//   SAP_VAR_CYCLE_EN  when defined, each instruction returns to T1 right
//                     after its last active T-state (OUT/NOP after T4,
//                     LDA after T5, ADD/SUB after T6). When undefined,
//                     every non-HLT instruction takes all six T-states.
module sap_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic [5:0] tstate,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       mem_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state;
    state_t state_next;

    // Opcode class decode; anything not listed behaves as NOP.
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;

    // Classify the opcode once so the state and output decodes stay readable.
    always_comb begin
        is_lda = (opcode == OP_LDA);
        is_add = (opcode == OP_ADD);
        is_sub = (opcode == OP_SUB);
        is_out = (opcode == OP_OUT);
        is_hlt = (opcode == OP_HLT);
    end

    // State register; rst forces T1 immediately, independent of clk and step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_T1;
        end else begin
            // NOTE: state is updated with <= so every process sampling it on
            // this edge sees the pre-edge value; blocking here would race.
            state <= state_next;
        end
    end

    // Next-state decode: advance one T-state per stepped edge; HALT is sticky.
    always_comb begin
        // NOTE: the hold value is assigned before the case so every path
        // drives state_next; a missing branch would otherwise infer a latch.
        state_next = state;
        if (step) begin
            case (state)
                S_T1: state_next = S_T2;
                S_T2: state_next = S_T3;
                S_T3: state_next = S_T4;
                S_T4: begin
                    if (is_hlt) begin
                        state_next = S_HALT;
                    end else begin
`ifdef SAP_VAR_CYCLE_EN
                        // Only LDA/ADD/SUB have work left after T4.
                        if (is_lda || is_add || is_sub) begin
                            state_next = S_T5;
                        end else begin
                            state_next = S_T1;
                        end
`else
                        state_next = S_T5;
`endif
                    end
                end
                S_T5: begin
`ifdef SAP_VAR_CYCLE_EN
                    // LDA completes in T5; only ADD/SUB need the ALU cycle.
                    if (is_add || is_sub) begin
                        state_next = S_T6;
                    end else begin
                        state_next = S_T1;
                    end
`else
                    state_next = S_T6;
`endif
                end
                S_T6:    state_next = S_T1;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_T1;
            endcase
        end
    end

    // Control-word decode from state and opcode; all signals default low.
    always_comb begin
        tstate   = 6'b000000;
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        mem_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        halted   = 1'b0;
        case (state)
            S_T1: begin
                // Fetch: PC address into MAR.
                tstate   = 6'b000001;
                pc_out   = 1'b1;
                mar_load = 1'b1;
            end
            S_T2: begin
                tstate = 6'b000010;
                pc_inc = 1'b1;
            end
            S_T3: begin
                // Fetch: instruction word into IR.
                tstate  = 6'b000100;
                mem_out = 1'b1;
                ir_load = 1'b1;
            end
            S_T4: begin
                tstate = 6'b001000;
                if (is_lda || is_add || is_sub) begin
                    // Operand address from the IR low nibble into MAR.
                    ir_out   = 1'b1;
                    mar_load = 1'b1;
                end else if (is_out) begin
                    a_out    = 1'b1;
                    out_load = 1'b1;
                end
            end
            S_T5: begin
                tstate = 6'b010000;
                if (is_lda) begin
                    mem_out = 1'b1;
                    a_load  = 1'b1;
                end else if (is_add || is_sub) begin
                    mem_out = 1'b1;
                    b_load  = 1'b1;
                end
            end
            S_T6: begin
                tstate = 6'b100000;
                if (is_add || is_sub) begin
                    alu_out = 1'b1;
                    alu_sub = is_sub;
                    a_load  = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                tstate = 6'b000000;
            end
        endcase
    end

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller -- directed bench for sap_controller.
//
// The stimulus thread drives step/opcode/rst and pushes the hand-computed
// expected T-state and control word into a scoreboard queue; a separate
// monitor pops each entry and compares it against the DUT outputs, also
// checking that no two bus drivers are on together.
`timescale 1ns/1ps
module tb_sap_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic       pc_out, pc_inc, mar_load, mem_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;

    sap_controller dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .opcode   (opcode),
        .tstate   (tstate),
        .pc_out   (pc_out),
        .pc_inc   (pc_inc),
        .mar_load (mar_load),
        .mem_out  (mem_out),
        .ir_load  (ir_load),
        .ir_out   (ir_out),
        .a_load   (a_load),
        .a_out    (a_out),
        .b_load   (b_load),
        .alu_out  (alu_out),
        .alu_sub  (alu_sub),
        .out_load (out_load),
        .halted   (halted)
    );

    // 20 ns period: rising edges at 10, 30, ...; falling edges at 20, 40, ...
    always #10 clk = ~clk;

    // Control word bit positions, MSB first.
    localparam logic [12:0] K_PC_OUT = 13'h1000;
    localparam logic [12:0] K_PC_INC = 13'h0800;
    localparam logic [12:0] K_MAR    = 13'h0400;
    localparam logic [12:0] K_MEM    = 13'h0200;
    localparam logic [12:0] K_IR_LD  = 13'h0100;
    localparam logic [12:0] K_IR_OUT = 13'h0080;
    localparam logic [12:0] K_A_LD   = 13'h0040;
    localparam logic [12:0] K_A_OUT  = 13'h0020;
    localparam logic [12:0] K_B_LD   = 13'h0010;
    localparam logic [12:0] K_ALU    = 13'h0008;
    localparam logic [12:0] K_SUB    = 13'h0004;
    localparam logic [12:0] K_OUT_LD = 13'h0002;
    localparam logic [12:0] K_HALT   = 13'h0001;
    localparam logic [12:0] K_NONE   = 13'h0000;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    localparam logic [5:0] TH = 6'b000000;

    logic [12:0] ctl_act;
    logic [4:0]  bus_act;
    assign ctl_act = {pc_out, pc_inc, mar_load, mem_out, ir_load, ir_out,
                      a_load, a_out, b_load, alu_out, alu_sub, out_load, halted};
    assign bus_act = {pc_out, mem_out, ir_out, a_out, alu_out};

    typedef struct {
        string       name;
        logic [5:0]  ts;
        logic [12:0] ctl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: compare every queued expectation when a sample is announced.
    initial begin
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_checks++;
                if (tstate !== mon_e.ts || ctl_act !== mon_e.ctl) begin
                    n_fail++;
                    $display("FAIL %s: got tstate=%b ctl=%b, expected tstate=%b ctl=%b",
                             mon_e.name, tstate, ctl_act, mon_e.ts, mon_e.ctl);
                end
                n_checks++;
                if ($countones(bus_act) > 1) begin
                    n_fail++;
                    $display("FAIL bus_%s: got drivers=%b, expected at most one set",
                             mon_e.name, bus_act);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string name, input logic [5:0] ts,
                              input logic [12:0] ctl);
        exp_t e;
        e.name = name;
        e.ts   = ts;
        e.ctl  = ctl;
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Drive inputs on the falling edge, sample 2 ns after the rising edge.
    task automatic edge_chk(input logic s, input logic [3:0] op, input string name,
                            input logic [5:0] ts, input logic [12:0] ctl);
        @(negedge clk);
        step   = s;
        opcode = op;
        @(posedge clk);
        #2;
        expect_out(name, ts, ctl);
    endtask

    // Assert rst between clock edges and check T1 before the next edge.
    task automatic async_reset(input string name);
        #2;
        rst = 1'b1;
        #2;
        expect_out(name, T1, K_PC_OUT | K_MAR);
        @(negedge clk);
        rst  = 1'b0;
        step = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        step   = 1'b0;
        opcode = 4'h0;
        #1;
        rst = 1'b1;
        #2;
        expect_out("reset_t1", T1, K_PC_OUT | K_MAR);
        edge_chk(1'b1, 4'h0, "reset_step_ignored", T1, K_PC_OUT | K_MAR);
        @(negedge clk);
        rst  = 1'b0;
        step = 1'b0;
        edge_chk(1'b0, 4'h0, "hold_t1", T1, K_PC_OUT | K_MAR);

        // LDA
        edge_chk(1'b1, 4'h0, "lda_t2", T2, K_PC_INC);
        edge_chk(1'b1, 4'h0, "lda_t3", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'h0, "lda_t4", T4, K_IR_OUT | K_MAR);
        edge_chk(1'b1, 4'h0, "lda_t5", T5, K_MEM | K_A_LD);
`ifndef SAP_VAR_CYCLE_EN
        edge_chk(1'b1, 4'h0, "lda_t6", T6, K_NONE);
`endif
        edge_chk(1'b1, 4'h0, "lda_t1", T1, K_PC_OUT | K_MAR);

        // SUB, with opcode churn during fetch that must have no effect
        edge_chk(1'b1, 4'hF, "sub_t2_opF", T2, K_PC_INC);
        edge_chk(1'b1, 4'hE, "sub_t3_opE", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'h2, "sub_t4", T4, K_IR_OUT | K_MAR);
        edge_chk(1'b1, 4'h2, "sub_t5", T5, K_MEM | K_B_LD);
        edge_chk(1'b1, 4'h2, "sub_t6", T6, K_ALU | K_SUB | K_A_LD);
        edge_chk(1'b1, 4'h2, "sub_t1", T1, K_PC_OUT | K_MAR);

        // ADD
        edge_chk(1'b1, 4'h1, "add_t2", T2, K_PC_INC);
        edge_chk(1'b1, 4'h1, "add_t3", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'h1, "add_t4", T4, K_IR_OUT | K_MAR);
        edge_chk(1'b1, 4'h1, "add_t5", T5, K_MEM | K_B_LD);
        edge_chk(1'b1, 4'h1, "add_t6", T6, K_ALU | K_A_LD);
        edge_chk(1'b1, 4'h1, "add_t1", T1, K_PC_OUT | K_MAR);

        // OUT
        edge_chk(1'b1, 4'hE, "out_t2", T2, K_PC_INC);
        edge_chk(1'b1, 4'hE, "out_t3", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'hE, "out_t4", T4, K_A_OUT | K_OUT_LD);
`ifndef SAP_VAR_CYCLE_EN
        edge_chk(1'b1, 4'hE, "out_t5", T5, K_NONE);
        edge_chk(1'b1, 4'hE, "out_t6", T6, K_NONE);
`endif
        edge_chk(1'b1, 4'hE, "out_t1", T1, K_PC_OUT | K_MAR);

        // NOP (opcode 5)
        edge_chk(1'b1, 4'h5, "nop_t2", T2, K_PC_INC);
        edge_chk(1'b1, 4'h5, "nop_t3", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'h5, "nop_t4", T4, K_NONE);
`ifndef SAP_VAR_CYCLE_EN
        edge_chk(1'b1, 4'h5, "nop_t5", T5, K_NONE);
        edge_chk(1'b1, 4'h5, "nop_t6", T6, K_NONE);
`endif
        edge_chk(1'b1, 4'h5, "nop_t1", T1, K_PC_OUT | K_MAR);

        // step gating: 1,0,0,1 from T2, then async reset in the middle of T5
        edge_chk(1'b1, 4'h1, "gate_t2", T2, K_PC_INC);
        edge_chk(1'b1, 4'h1, "gate_t3", T3, K_MEM | K_IR_LD);
        edge_chk(1'b0, 4'h1, "gate_hold1", T3, K_MEM | K_IR_LD);
        edge_chk(1'b0, 4'h1, "gate_hold2", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'h1, "gate_t4", T4, K_IR_OUT | K_MAR);
        edge_chk(1'b1, 4'h1, "gate_t5", T5, K_MEM | K_B_LD);
        async_reset("rst_mid_t5");
        edge_chk(1'b1, 4'hF, "post_rst_t2", T2, K_PC_INC);

        // HLT: sticky HALT, step and opcode ignored, exit only through rst
        edge_chk(1'b1, 4'hF, "hlt_t3", T3, K_MEM | K_IR_LD);
        edge_chk(1'b1, 4'hF, "hlt_t4", T4, K_NONE);
        edge_chk(1'b1, 4'hF, "hlt_enter", TH, K_HALT);
        for (int i = 0; i < 9; i++) begin
            edge_chk(1'b1, 4'(i), $sformatf("hlt_stay%0d", i), TH, K_HALT);
        end
        edge_chk(1'b0, 4'h1, "hlt_stay_nostep", TH, K_HALT);
        async_reset("hlt_rst");
        edge_chk(1'b1, 4'h0, "hlt_exit_t2", T2, K_PC_INC);

        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
